// File: rtl/mod_m_counter_pkg.sv
// ---------------------------------------------------------------------------
// Module : mod_m_counter_pkg
// Brief  : Default constants and width helper for the modulo-M counter.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package mod_m_counter_pkg;

  localparam int MOD_M_DEFAULT       = 5;
  localparam int MOD_M_WIDTH_DEFAULT = 3;

  // Smallest width n with 2**n >= m; a modulus below 2 still needs one bit.
  function automatic int clog2_min(input int m);
    int n;
    n = 1;
    while ((1 << n) < m) begin
      n = n + 1;
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_m_next.sv
// ---------------------------------------------------------------------------
// Module : mod_m_next
// Brief  : Combinational next-state and terminal decode for mod_m_counter.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mod_m_next #(
  parameter int N = 3
) (
  input  logic [N-1:0] i_cnt,
  input  logic [N-1:0] i_terminal,
  output logic [N-1:0] o_nxt,
  output logic         o_is_terminal
);

  // Anything at or past the terminal value folds back to zero, which also
  // pulls an out-of-range state back into the legal sequence.
  always_comb begin
    o_nxt = i_cnt + N'(1);
    if (i_cnt >= i_terminal) begin
      o_nxt = '0;
    end
  end

  assign o_is_terminal = (i_cnt == i_terminal);

endmodule

`default_nettype wire

// File: rtl/mod_m_counter.sv
// ---------------------------------------------------------------------------
// Module : mod_m_counter
// Brief  : Free-running modulo-M up-counter with a terminal-count tick.
//          Define MOD_M_COUNTER_CHECK_EN to compile parameter and run-time checks.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mod_m_counter
  import mod_m_counter_pkg::*;
#(
  parameter int M = MOD_M_DEFAULT,
  parameter int N = MOD_M_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  output logic         complete_tick,
  output logic [N-1:0] count
);

  localparam logic [N-1:0] c_TERMINAL = N'(M - 1);

  logic [N-1:0] r_cnt;
  logic [N-1:0] w_nxt;
  logic         w_is_terminal;

  mod_m_next #(
    .N (N)
  ) u_next (
    .i_cnt         (r_cnt),
    .i_terminal    (c_TERMINAL),
    .o_nxt         (w_nxt),
    .o_is_terminal (w_is_terminal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_nxt;
    end
  end

  assign count         = r_cnt;
  assign complete_tick = w_is_terminal;

`ifdef MOD_M_COUNTER_CHECK_EN
  generate
    if (M < 2 || N < clog2_min(M)) begin : g_param_bad
      $fatal(1, "mod_m_counter: illegal parameters M=%0d N=%0d", M, N);
    end
  endgenerate

  // r_chk_seq marks that the previous edge was a checked counting edge, so
  // the step from r_chk_prev to the current count can be verified.
  logic         r_chk_valid;
  logic         r_chk_seq;
  logic [N-1:0] r_chk_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chk_valid <= 1'b1;
      r_chk_seq   <= 1'b0;
      r_chk_prev  <= '0;
    end else begin
      if (r_chk_valid) begin
        assert (int'(count) < M)
          else $error("%0t mod_m_counter: count=%0d out of range (M=%0d)", $time, count, M);
        assert (complete_tick == (count == c_TERMINAL))
          else $error("%0t mod_m_counter: tick=%0b with count=%0d", $time, complete_tick, count);
      end
      if (r_chk_seq) begin
        assert (int'(count) == ((int'(r_chk_prev) + 1) % M))
          else $error("%0t mod_m_counter: step %0d -> %0d", $time, r_chk_prev, count);
      end
      r_chk_prev <= count;
      r_chk_seq  <= r_chk_valid;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod_m_counter.sv
// ---------------------------------------------------------------------------
// Module : tb_mod_m_counter
// Brief  : Scoreboard bench for mod_m_counter at M=12/N=4, M=2/N=1, M=16/N=4.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mod_m_counter;

  typedef struct {
    int c12;
    int t12;
    int c2;
    int t2;
    int c16;
    int t16;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] w_cnt12;
  logic       w_tick12;
  logic [0:0] w_cnt2;
  logic       w_tick2;
  logic [3:0] w_cnt16;
  logic       w_tick16;

  exp_t sb[$];
  int   n_err;
  int   n_chk;
  int   m12;
  int   m2;
  int   m16;

  mod_m_counter #(.M(12), .N(4)) u_dut12 (
    .clk           (clk),
    .reset         (reset),
    .complete_tick (w_tick12),
    .count         (w_cnt12)
  );

  mod_m_counter #(.M(2), .N(1)) u_dut2 (
    .clk           (clk),
    .reset         (reset),
    .complete_tick (w_tick2),
    .count         (w_cnt2)
  );

  mod_m_counter #(.M(16), .N(4)) u_dut16 (
    .clk           (clk),
    .reset         (reset),
    .complete_tick (w_tick16),
    .count         (w_cnt16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_next(input int cur, input int m, input bit rst);
    if (rst) return 0;
    if (cur >= m - 1) return 0;
    return cur + 1;
  endfunction

  // Drive one cycle: predict, push, clock, then pop and compare at negedge.
  task automatic step(input bit rst);
    exp_t e;
    reset = rst;
    m12 = model_next(m12, 12, rst);
    m2  = model_next(m2, 2, rst);
    m16 = model_next(m16, 16, rst);
    e.c12 = m12; e.t12 = (m12 == 11) ? 1 : 0;
    e.c2  = m2;  e.t2  = (m2 == 1) ? 1 : 0;
    e.c16 = m16; e.t16 = (m16 == 15) ? 1 : 0;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check_eq("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("m12_count", int'(w_cnt12), e.c12);
      check_eq("m12_tick", int'(w_tick12), e.t12);
      check_eq("m2_count", int'(w_cnt2), e.c2);
      check_eq("m2_tick", int'(w_tick2), e.t2);
      check_eq("m16_count", int'(w_cnt16), e.c16);
      check_eq("m16_tick", int'(w_tick16), e.t16);
    end
  endtask

  initial begin
    int tbl[12];
    int ticks;
    int maxc;
    n_err = 0;
    n_chk = 0;
    m12 = 0;
    m2 = 0;
    m16 = 0;
    reset = 1'b1;
    @(negedge clk);

    // Reset state
    step(1'b1);
    check_eq("reset_count", int'(w_cnt12), 0);
    check_eq("reset_tick", int'(w_tick12), 0);

    // Count-up against an explicit table 1..b,0
    for (int i = 0; i < 12; i++) tbl[i] = (i + 1) % 12;
    for (int i = 0; i < 12; i++) begin
      step(1'b0);
      check_eq("table_count", int'(w_cnt12), tbl[i]);
      check_eq("table_tick", int'(w_tick12), (i == 10) ? 1 : 0);
    end

    // Reset mid-operation at count=7
    for (int i = 0; i < 7; i++) step(1'b0);
    check_eq("pre_reset_count", int'(w_cnt12), 7);
    step(1'b1);
    check_eq("mid_reset_count", int'(w_cnt12), 0);
    step(1'b0);
    check_eq("resume_count", int'(w_cnt12), 1);

    // Long free run from reset: 100 edges
    step(1'b1);
    ticks = 0;
    maxc = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0);
      if (w_tick12) ticks = ticks + 1;
      if (int'(w_cnt12) > maxc) maxc = int'(w_cnt12);
    end
    check_eq("long_ticks", ticks, 8);
    check_eq("long_max_le_b", (maxc <= 11) ? 1 : 0, 1);
    check_eq("long_max", maxc, 11);
    check_eq("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
